// File: rtl/snake_key_sched.sv
// Keyboard-to-snake command scheduler: decoder handshake, key filtering, direction FIFO, tick release.
// Optional: define SNAKE_WASD_EN to also steer with w/a/s/d (either case).
module snake_key_sched #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          kbd_ready,
   input  logic [7:0]    kbd_code,
   input  logic          kbd_released,
   input  logic          kbd_err,
   output logic          kbd_read,
   input  logic          tick,
   input  logic          clr,
   output logic [1:0]    dir,
   output logic          dir_upd,
   output logic          paused,
   output logic [AW:0]   fifo_cnt,
   output logic          ovf
);

   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {H_IDLE, H_ACK, H_WAIT} hs_state_t;

   hs_state_t     state, state_nxt;
   logic [7:0]    code_q;
   logic          rel_q, err_q;
   logic [1:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [1:0]    last_push;

   logic          is_dir, is_pause, full, empty, dup, push, ovf_set, pop, accept;
   logic [1:0]    cmd, pop_val;

   // Handshake state register, latched event and registered read strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= H_IDLE;
         kbd_read <= 1'b0;
         code_q   <= 8'h00;
         rel_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state    <= state_nxt;
         kbd_read <= (state_nxt == H_ACK);
         if (state == H_IDLE && kbd_ready) begin
            code_q <= kbd_code;
            rel_q  <= kbd_released;
            err_q  <= kbd_err;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         H_IDLE:  if (kbd_ready) state_nxt = H_ACK;
         H_ACK:   state_nxt = H_WAIT;
         H_WAIT:  if (!kbd_ready) state_nxt = H_IDLE;
         default: state_nxt = H_IDLE;
      endcase
   end

   // Key classification on the latched event while acknowledging it
   always_comb begin
      is_dir   = 1'b0;
      is_pause = 1'b0;
      cmd      = 2'b00;
      if (state == H_ACK && !rel_q && !err_q) begin
         case (code_q)
            8'h90, 8'h91, 8'h92, 8'h93: begin
               is_dir = 1'b1;
               cmd    = code_q[1:0];
            end
            8'h20, 8'h1B: is_pause = 1'b1;
`ifdef SNAKE_WASD_EN
            8'h77, 8'h57: begin is_dir = 1'b1; cmd = 2'b10; end
            8'h61, 8'h41: begin is_dir = 1'b1; cmd = 2'b01; end
            8'h73, 8'h53: begin is_dir = 1'b1; cmd = 2'b11; end
            8'h64, 8'h44: begin is_dir = 1'b1; cmd = 2'b00; end
`endif
            default: ;
         endcase
      end
   end

   // Duplicates are checked before fullness so typematic repeats never raise ovf
   always_comb begin
      full    = (fifo_cnt == CW'(DEPTH));
      empty   = (fifo_cnt == '0);
      dup     = !empty && (cmd == last_push);
      push    = is_dir && !clr && !dup && !full;
      ovf_set = is_dir && !clr && !dup && full;
      pop     = tick && !paused && !empty && !clr;
      pop_val = mem[rd_ptr];
      accept  = pop && (pop_val != dir) && (pop_val != (dir ^ 2'b01));
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= cmd;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         fifo_cnt  <= '0;
         ovf       <= 1'b0;
         last_push <= 2'b00;
         dir       <= 2'b00;
         dir_upd   <= 1'b0;
         paused    <= 1'b0;
      end else begin
         dir_upd <= accept;
         if (accept) dir <= pop_val;
         if (is_pause) paused <= !paused;
         if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            ovf      <= 1'b0;
         end else begin
            if (ovf_set) ovf <= 1'b1;
            if (push) begin
               wr_ptr    <= wr_ptr + AW'(1);
               last_push <= cmd;
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      fifo_cnt <= fifo_cnt + CW'(1);
            else if (pop && !push) fifo_cnt <= fifo_cnt - CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_snake_key_sched.sv
// Randomized + directed bench for snake_key_sched against a queue-based command model.
module tb_snake_key_sched;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned AW    = 2;

   logic          clk = 1'b0;
   logic          rst_n, kbd_ready, kbd_released, kbd_err, kbd_read, tick, clr;
   logic [7:0]    kbd_code;
   logic [1:0]    dir;
   logic          dir_upd, paused, ovf;
   logic [AW:0]   fifo_cnt;

   always #5 clk = ~clk;

   snake_key_sched #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .kbd_ready(kbd_ready), .kbd_code(kbd_code),
      .kbd_released(kbd_released), .kbd_err(kbd_err), .kbd_read(kbd_read),
      .tick(tick), .clr(clr), .dir(dir), .dir_upd(dir_upd), .paused(paused),
      .fifo_cnt(fifo_cnt), .ovf(ovf)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: command queue plus game-level state
   logic [1:0] q[$];
   logic [1:0] m_dir, m_last;
   bit         m_paused, m_ovf, m_upd, m_read;
   int         m_phase;
   logic [7:0] m_code;
   bit         m_rel, m_err;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int classify(input logic [7:0] c);
      if (c >= 8'h90 && c <= 8'h93) return int'(c - 8'h90);
      case (c)
         8'h20, 8'h1B: return 4;
`ifdef SNAKE_WASD_EN
         8'h77, 8'h57: return 2;
         8'h61, 8'h41: return 1;
         8'h73, 8'h53: return 3;
         8'h64, 8'h44: return 0;
`endif
         default: return -1;
      endcase
   endfunction

   task automatic model_reset();
      q.delete();
      m_dir = 2'b00; m_last = 2'b00;
      m_paused = 0; m_ovf = 0; m_upd = 0; m_read = 0;
      m_phase = 0; m_code = 8'h00; m_rel = 0; m_err = 0;
   endtask

   task automatic model_step();
      int k;
      int sz;
      logic [1:0] pv;
      sz = q.size();
      k = -1;
      if (m_phase == 1 && !m_rel && !m_err) k = classify(m_code);
      m_upd = 0;
      if (tick && !m_paused && sz > 0 && !clr) begin
         pv = q.pop_front();
         // only perpendicular turns take effect
         if (pv[1] != m_dir[1]) begin
            m_dir = pv;
            m_upd = 1;
         end
      end
      if (k == 4) m_paused = !m_paused;
      if (clr) begin
         q.delete();
         m_ovf = 0;
      end else if (k >= 0 && k < 4) begin
         if (sz > 0 && 2'(k) == m_last) ;
         else if (sz == int'(DEPTH)) m_ovf = 1;
         else begin
            q.push_back(2'(k));
            m_last = 2'(k);
         end
      end
      case (m_phase)
         0: if (kbd_ready) begin
               m_phase = 1; m_code = kbd_code; m_rel = kbd_released; m_err = kbd_err;
            end
         1: m_phase = 2;
         default: if (!kbd_ready) m_phase = 0;
      endcase
      m_read = (m_phase == 1);
   endtask

   task automatic check_all();
      chk("kbd_read", 32'(kbd_read), 32'(m_read));
      chk("dir",      32'(dir),      32'(m_dir));
      chk("dir_upd",  32'(dir_upd),  32'(m_upd));
      chk("paused",   32'(paused),   32'(m_paused));
      chk("fifo_cnt", 32'(fifo_cnt), 32'(q.size()));
      chk("ovf",      32'(ovf),      32'(m_ovf));
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic press(input logic [7:0] c, input logic rel, input logic err);
      kbd_ready = 1'b1; kbd_code = c; kbd_released = rel; kbd_err = err;
      step();
      chk("read_pulse", 32'(kbd_read), 32'd1);
      step();
      chk("read_single", 32'(kbd_read), 32'd0);
      step();
      kbd_ready = 1'b0;
      step();
   endtask

   task automatic do_tick();
      tick = 1'b1;
      step();
      tick = 1'b0;
   endtask

   logic [7:0] pool [18] = '{8'h90, 8'h91, 8'h92, 8'h93, 8'h90, 8'h91, 8'h92, 8'h93, 8'h20,
                             8'h1B, 8'h77, 8'h61, 8'h73, 8'h64, 8'h57, 8'h41, 8'h53, 8'h44};

   initial begin
      rst_n = 1'b0; kbd_ready = 1'b0; kbd_code = 8'h00; kbd_released = 1'b0;
      kbd_err = 1'b0; tick = 1'b0; clr = 1'b0;
      model_reset();
      #12;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // first press and first tick
      press(8'h92, 1'b0, 1'b0);
      chk("first_cnt", 32'(fifo_cnt), 32'd1);
      do_tick();
      chk("first_dir", 32'(dir), 32'd2);
      chk("first_upd", 32'(dir_upd), 32'd1);
      step();

      // back to right, then a reversal to left is rejected
      press(8'h90, 1'b0, 1'b0);
      do_tick();
      press(8'h91, 1'b0, 1'b0);
      do_tick();
      chk("rev_dir", 32'(dir), 32'd0);
      chk("rev_upd", 32'(dir_upd), 32'd0);
      chk("rev_cnt", 32'(fifo_cnt), 32'd0);

      // overflow then clear
      for (int i = 0; i < 6; i++) press((i % 2 == 0) ? 8'h92 : 8'h93, 1'b0, 1'b0);
      chk("full_cnt", 32'(fifo_cnt), 32'd4);
      chk("full_ovf", 32'(ovf), 32'd1);
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("clr_cnt", 32'(fifo_cnt), 32'd0);
      chk("clr_ovf", 32'(ovf), 32'd0);

      // pause blocks ticks
      press(8'h20, 1'b0, 1'b0);
      chk("pause_on", 32'(paused), 32'd1);
      press(8'h92, 1'b0, 1'b0);
      do_tick();
      chk("pause_dir", 32'(dir), 32'd0);
      chk("pause_cnt", 32'(fifo_cnt), 32'd1);
      press(8'h20, 1'b0, 1'b0);
      do_tick();
      chk("resume_dir", 32'(dir), 32'd2);

      // typematic repeats and dropped events
      for (int i = 0; i < 3; i++) press(8'h93, 1'b0, 1'b0);
      press(8'h90, 1'b1, 1'b0);
      press(8'h91, 1'b0, 1'b1);
      chk("dup_cnt", 32'(fifo_cnt), 32'd1);

      // push and pop in the same cycle
      press(8'h92, 1'b0, 1'b0);
      kbd_ready = 1'b1; kbd_code = 8'h90; kbd_released = 1'b0; kbd_err = 1'b0;
      step();
      tick = 1'b1;
      step();
      tick = 1'b0;
      chk("pushpop_cnt", 32'(fifo_cnt), 32'd2);
      kbd_ready = 1'b0;
      step();
      step();

      // reset while acknowledging; pending event is re-acknowledged afterwards
      kbd_ready = 1'b1; kbd_code = 8'h93;
      step();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      #2 rst_n = 1'b1;
      step();
      chk("reack", 32'(kbd_read), 32'd1);
      step();
      kbd_ready = 1'b0;
      step();

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         tick = ($urandom_range(0, 3) == 0);
         clr  = ($urandom_range(0, 63) == 0);
         if (kbd_ready) begin
            if ($urandom_range(0, 2) == 0) kbd_ready = 1'b0;
         end else if ($urandom_range(0, 2) == 0) begin
            kbd_ready    = 1'b1;
            kbd_code     = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 17)];
            kbd_released = ($urandom_range(0, 7) == 0);
            kbd_err      = ($urandom_range(0, 15) == 0);
         end
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
